// File: rtl/mem_ctrl.sv
// Asynchronous SRAM controller: one read or write per request, each strobe held
// low for WAIT_CYCLES clocks, followed by a one-cycle bus turnaround.
module mem_ctrl #(
    parameter int ADDRLEN     = 8,
    parameter int WAIT_CYCLES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [ADDRLEN-1:0] req_addr,
    input  logic [7:0]         req_wdata,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               mem_oe_,
    output logic               mem_we_,
    output logic [ADDRLEN-1:0] mem_addr,
    inout  wire  [7:0]         mem_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

    logic [1:0]         r_state;
    logic [ADDRLEN-1:0] r_addr;
    logic [7:0]         r_wdata;
    logic               r_we;
    logic [7:0]         r_cnt;
    logic               r_rsp_valid;
    logic [7:0]         r_rdata;

    logic               w_accept;
    logic               w_drive;

    assign w_accept = req_valid && (r_state == IDLE);

    // Write data stays on the bus through TURN so the SRAM sees hold time after mem_we_ rises.
    assign w_drive  = (r_state == WRITE) || ((r_state == TURN) && r_we);

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign mem_oe_   = (r_state != READ);
    assign mem_we_   = (r_state != WRITE);
    assign mem_addr  = r_addr;
    assign mem_data  = w_drive ? r_wdata : 8'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= 8'h00;
            r_we        <= 1'b0;
            r_cnt       <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_we    <= req_we;
                        r_cnt   <= CNT_LOAD;
                        r_state <= req_we ? WRITE : READ;
                    end
                end
                READ: begin
                    if (r_cnt == 8'h00) begin
                        r_rdata     <= mem_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= TURN;
                    end else begin
                        r_cnt <= r_cnt - 8'h01;
                    end
                end
                WRITE: begin
                    if (r_cnt == 8'h00) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= TURN;
                    end else begin
                        r_cnt <= r_cnt - 8'h01;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: two instances (WAIT_CYCLES 6 and 1), each
// with its own SRAM model, checked through a response scoreboard and per-cycle bus monitors.
module tb_mem_ctrl;

    typedef struct {
        int         inst;
        logic [7:0] data;
    } expEntryT;

    logic       clk;
    logic       reset;
    logic [1:0] reqValid;
    logic       reqWe;
    logic [7:0] reqAddr;
    logic [7:0] reqWdata;
    wire  [1:0] reqReady;
    wire  [1:0] rspValid;
    wire  [1:0] oeN;
    wire  [1:0] weN;
    wire  [7:0] rspRdata [2];
    wire  [7:0] memAddr [2];

    logic [7:0] refMem [256];
    logic [7:0] modelRd [2];
    logic [7:0] tbWdata;
    expEntryT   expQ [$];
    int         total;
    int         bad;
    int         rspCount;
    int         issueCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int waitOf(input int sel);
        return (sel == 0) ? 6 : 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int W = (g == 0) ? 6 : 1;
        wire  [7:0] memData;
        logic [7:0] sram [256];
        int         oeLen = 0;
        int         weLen = 0;
        logic       prevStrobe = 1'b0;
        logic       prevWeLow = 1'b0;
        logic       prevRsp = 1'b0;
        logic [7:0] prevAddr = 8'h00;

        initial begin
            for (int i = 0; i < 256; i++) sram[i] = 8'h00;
            sram[1] = 8'hf0;
            sram[2] = 8'h01;
        end

        assign memData = !oeN[g] ? sram[memAddr[g]] : 8'bz;

        // The SRAM latches write data on the rising edge of its write strobe.
        always @(posedge weN[g]) sram[memAddr[g]] = memData;

        mem_ctrl #(.ADDRLEN(8), .WAIT_CYCLES(W)) dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (reqValid[g]),
            .req_we    (reqWe),
            .req_addr  (reqAddr),
            .req_wdata (reqWdata),
            .req_ready (reqReady[g]),
            .rsp_valid (rspValid[g]),
            .rsp_rdata (rspRdata[g]),
            .mem_oe_   (oeN[g]),
            .mem_we_   (weN[g]),
            .mem_addr  (memAddr[g]),
            .mem_data  (memData)
        );

        always @(negedge clk) begin
            if (reset) begin
                oeLen   = 0;
                weLen   = 0;
                prevRsp = 1'b0;
            end else begin
                checkOutput("strobeOverlap", 32'({oeN[g], weN[g]} == 2'b00), 0);
                checkOutput("driveWhileOe", 32'(dut.w_drive && !oeN[g]), 0);
                if (prevStrobe && (!oeN[g] || !weN[g]))
                    checkOutput("addrStable", memAddr[g], prevAddr);
                if (!oeN[g]) oeLen++;
                else if (oeLen != 0) begin
                    checkOutput("oeLowLen", oeLen, W);
                    oeLen = 0;
                end
                if (!weN[g]) begin
                    weLen++;
                    checkOutput("wrData", memData, tbWdata);
                end else if (weLen != 0) begin
                    checkOutput("weLowLen", weLen, W);
                    checkOutput("wrHold", memData, tbWdata);
                    weLen = 0;
                end
                if (rspValid[g]) begin
                    rspCount++;
                    checkOutput("rspSingle", 32'(prevRsp), 0);
                    if (expQ.size() == 0) begin
                        checkOutput("rspUnexpected", 32'(rspValid[g]), 0);
                    end else begin
                        expEntryT e;
                        e = expQ.pop_front();
                        checkOutput("rspInst", g, e.inst);
                        checkOutput("rspRdata", rspRdata[g], e.data);
                    end
                end
                prevRsp = rspValid[g];
            end
            prevStrobe = !oeN[g] || !weN[g];
            prevAddr   = memAddr[g];
        end
    end

    // Waits for ready, presents one request and returns just after the accepting edge.
    task automatic issue(input int sel, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        int k = 0;
        while (!reqReady[sel] && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("readyWait", 32'(reqReady[sel]), 1);
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = wd;
        if (we) begin
            tbWdata      = wd;
            refMem[addr] = wd;
        end else begin
            modelRd[sel] = refMem[addr];
        end
        expQ.push_back('{inst: sel, data: modelRd[sel]});
        issueCount++;
        reqValid[sel] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int sel);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!reqReady[sel] && k < 50);
        checkOutput("readyLatency", k, waitOf(sel) + 2);
    endtask

    task automatic applyStimulus(input int sel, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        issue(sel, we, addr, wd);
        waitDone(sel);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        total      = 0;
        bad        = 0;
        rspCount   = 0;
        issueCount = 0;
        tbWdata    = 8'h00;
        modelRd[0] = 8'h00;
        modelRd[1] = 8'h00;
        for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
        refMem[1] = 8'hf0;
        refMem[2] = 8'h01;
        reset    = 1'b1;
        reqValid = 2'b01;
        reqWe    = 1'b0;
        reqAddr  = 8'h01;
        reqWdata = 8'h00;

        // Reset held with a pending request: nothing may start.
        repeat (3) @(negedge clk);
        checkOutput("rstOe", 32'(oeN[0]), 1);
        checkOutput("rstWe", 32'(weN[0]), 1);
        checkOutput("rstAddr", memAddr[0], 0);
        checkOutput("rstRspValid", 32'(rspValid[0]), 0);
        checkOutput("rstRdata", rspRdata[0], 0);
        checkOutput("rstReady", 32'(reqReady[0]), 1);
        reqValid = 2'b00;
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterRst", 32'(reqReady[0]), 1);

        $display("[TB] single read");
        applyStimulus(0, 1'b0, 8'h01, 8'h00);
        reqValid[0] = 1'b0;

        $display("[TB] write then read");
        applyStimulus(0, 1'b1, 8'h20, 8'hA5);
        applyStimulus(0, 1'b0, 8'h20, 8'h00);
        reqValid[0] = 1'b0;

        $display("[TB] back-to-back reads");
        applyStimulus(0, 1'b0, 8'h00, 8'h00);
        applyStimulus(0, 1'b0, 8'h01, 8'h00);
        applyStimulus(0, 1'b0, 8'h02, 8'h00);
        reqValid[0] = 1'b0;

        $display("[TB] reset during read");
        issue(0, 1'b0, 8'h02, 8'h00);
        reqValid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        expQ.delete();
        issueCount--;
        modelRd[0] = 8'h00;
        modelRd[1] = 8'h00;
        checkOutput("abortOe", 32'(oeN[0]), 1);
        checkOutput("abortRspValid", 32'(rspValid[0]), 0);
        checkOutput("abortRdata", rspRdata[0], 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abortReady", 32'(reqReady[0]), 1);
        repeat (10) @(negedge clk);

        $display("[TB] single read, one wait cycle");
        applyStimulus(1, 1'b0, 8'h01, 8'h00);
        reqValid[1] = 1'b0;
        repeat (5) @(negedge clk);

        checkOutput("queueEmpty", expQ.size(), 0);
        checkOutput("rspCount", rspCount, issueCount);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
